// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: hazard/branch status in, stage controls and debug counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             exmem_branch;
  logic             exmem_zero;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pcsrc;
  logic             stalling;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline side
  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, exmem_branch, exmem_zero,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pcsrc,
           stalling, stall_cnt, flush_cnt
  );

  // controller side
  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, exmem_branch, exmem_zero,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pcsrc,
           stalling, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush sequencer; all controls are combinational from state + inputs.
// Taken branch overrides everything, an ongoing stall overrides a fresh hazard.
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int REM_W = $clog2(STALL_CYCLES) + 1;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);

  typedef enum logic {IDLE, STALL} state_t;

  state_t           state, state_nxt;
  logic [REM_W-1:0] remaining, rem_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             haz, tkn, stall_evt;

  assign haz = bus.idex_memread && (bus.idex_rt != 5'd0) &&
               ((bus.idex_rt == bus.ifid_rs) || (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));
  assign tkn = bus.exmem_branch && bus.exmem_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      if (stall_evt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (tkn && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt       = state;
    rem_nxt         = remaining;
    stall_evt       = 1'b0;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.pcsrc       = 1'b0;
    // raw status: reflects STALL or a detected hazard even when a branch wins
    bus.stalling    = (state == STALL) || haz;

    if (tkn) begin
      bus.pcsrc       = 1'b1;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
      state_nxt       = IDLE;
      rem_nxt         = '0;
    end else if (state == STALL) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      if (remaining == '0)
        state_nxt = IDLE;
      else
        rem_nxt = remaining - REM_W'(1);
    end else if (haz) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      stall_evt       = 1'b1;
      // a single-cycle stall needs no STALL state: the load has moved on by the next edge
      if (STALL_CYCLES > 1) begin
        state_nxt = STALL;
        rem_nxt   = REM_INIT;
      end
    end

    if (!rst) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_flush  = 1'b0;
      bus.exmem_flush = 1'b0;
      bus.pcsrc       = 1'b0;
      bus.stalling    = 1'b0;
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Drives three hazard_ctrl variants (1-cycle stall, 3-cycle stall, 2-bit counters) with shared stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       memread = 1'b0, uses_rt = 1'b0, br = 1'b0, zero = 1'b0;
  logic [4:0] rt_ex = 5'd0, rs_id = 5'd0, rt_id = 5'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) if1 ();
  hazard_ctrl_if #(.CNT_W(16)) if3 ();
  hazard_ctrl_if #(.CNT_W(2))  ifs ();

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(2))  dsat (.clk(clk), .rst(rst), .bus(ifs));

  assign if1.idex_memread = memread; assign if3.idex_memread = memread; assign ifs.idex_memread = memread;
  assign if1.idex_rt      = rt_ex;   assign if3.idex_rt      = rt_ex;   assign ifs.idex_rt      = rt_ex;
  assign if1.ifid_rs      = rs_id;   assign if3.ifid_rs      = rs_id;   assign ifs.ifid_rs      = rs_id;
  assign if1.ifid_rt      = rt_id;   assign if3.ifid_rt      = rt_id;   assign ifs.ifid_rt      = rt_id;
  assign if1.ifid_uses_rt = uses_rt; assign if3.ifid_uses_rt = uses_rt; assign ifs.ifid_uses_rt = uses_rt;
  assign if1.exmem_branch = br;      assign if3.exmem_branch = br;      assign ifs.exmem_branch = br;
  assign if1.exmem_zero   = zero;    assign if3.exmem_zero   = zero;    assign ifs.exmem_zero   = zero;

  // flags: {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pcsrc, stalling}
  logic [7:0]  flg [3];
  logic [31:0] scnt_o [3];
  logic [31:0] fcnt_o [3];

  assign flg[0] = {if1.pc_write, if1.ifid_write, if1.idex_bubble, if1.ifid_flush,
                   if1.idex_flush, if1.exmem_flush, if1.pcsrc, if1.stalling};
  assign flg[1] = {if3.pc_write, if3.ifid_write, if3.idex_bubble, if3.ifid_flush,
                   if3.idex_flush, if3.exmem_flush, if3.pcsrc, if3.stalling};
  assign flg[2] = {ifs.pc_write, ifs.ifid_write, ifs.idex_bubble, ifs.ifid_flush,
                   ifs.idex_flush, ifs.exmem_flush, ifs.pcsrc, ifs.stalling};
  assign scnt_o[0] = 32'(if1.stall_cnt); assign fcnt_o[0] = 32'(if1.flush_cnt);
  assign scnt_o[1] = 32'(if3.stall_cnt); assign fcnt_o[1] = 32'(if3.flush_cnt);
  assign scnt_o[2] = 32'(ifs.stall_cnt); assign fcnt_o[2] = 32'(ifs.flush_cnt);

  // Model: "owed" = stall cycles still due after the current one; counters as saturating integers.
  int sc_len [3] = '{1, 3, 1};
  int cmax   [3] = '{65535, 65535, 3};
  int owed   [3] = '{0, 0, 0};
  int m_scnt [3] = '{0, 0, 0};
  int m_fcnt [3] = '{0, 0, 0};

  function automatic logic m_haz();
    return memread && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));
  endfunction

  function automatic logic [7:0] exp_flags(int i);
    logic stl;
    if (!rst) return 8'b0010_0000;
    stl = (owed[i] > 0) || m_haz();
    if (br && zero) return {7'b1101111, stl};
    if (stl)        return 8'b0010_0001;
    return 8'b1100_0000;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        owed[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
      end else if (br && zero) begin
        owed[i] = 0;
        if (m_fcnt[i] < cmax[i]) m_fcnt[i]++;
      end else if (owed[i] > 0) begin
        owed[i]--;
      end else if (m_haz()) begin
        owed[i] = sc_len[i] - 1;
        if (m_scnt[i] < cmax[i]) m_scnt[i]++;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d flags", i), 32'(flg[i]), 32'(exp_flags(i)));
      chk($sformatf("dut%0d stall_cnt", i), scnt_o[i], 32'(m_scnt[i]));
      chk($sformatf("dut%0d flush_cnt", i), fcnt_o[i], 32'(m_fcnt[i]));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    memread = 1'b0; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    uses_rt = 1'b0; br = 1'b0; zero = 1'b0;
  endtask

  task automatic set_haz();
    memread = 1'b1; rt_ex = 5'd8; rs_id = 5'd8;
  endtask

  initial begin
    // reset held with a hazard present
    set_haz();
    repeat (3) smp();
    chk("rst pc_write", 32'(if1.pc_write), 32'd0);
    chk("rst bubble", 32'(if1.idex_bubble), 32'd1);
    chk("rst stalling", 32'(if1.stalling), 32'd0);
    chk("rst stall_cnt", 32'(if1.stall_cnt), 32'd0);
    chk("rst flush_cnt", 32'(if1.flush_cnt), 32'd0);

    nxt(); rst = 1'b1; idle();
    smp();
    chk("release pc_write", 32'(if1.pc_write), 32'd1);
    chk("release ifid_write", 32'(if1.ifid_write), 32'd1);

    // load-use on rs; dut3 must stall exactly 3 cycles
    nxt(); set_haz();
    smp();
    chk("lu pc_write", 32'(if1.pc_write), 32'd0);
    chk("lu ifid_write", 32'(if1.ifid_write), 32'd0);
    chk("lu bubble", 32'(if1.idex_bubble), 32'd1);
    chk("x3 stall c1", 32'(if3.stalling), 32'd1);
    nxt(); idle();
    smp();
    chk("lu resume", 32'(if1.pc_write), 32'd1);
    chk("lu stall_cnt", 32'(if1.stall_cnt), 32'd1);
    chk("x3 stall c2", 32'(if3.stalling), 32'd1);
    nxt(); smp();
    chk("x3 stall c3", 32'(if3.stalling), 32'd1);
    nxt(); smp();
    chk("x3 done stalling", 32'(if3.stalling), 32'd0);
    chk("x3 done pc_write", 32'(if3.pc_write), 32'd1);
    chk("x3 stall_cnt", 32'(if3.stall_cnt), 32'd1);

    // rt match gated by ifid_uses_rt
    nxt(); memread = 1'b1; rt_ex = 5'd9; rt_id = 5'd9; rs_id = 5'd3; uses_rt = 1'b0;
    smp();
    chk("rt unused stalling", 32'(if1.stalling), 32'd0);
    chk("rt unused pc_write", 32'(if1.pc_write), 32'd1);
    nxt(); uses_rt = 1'b1;
    smp();
    chk("rt used pc_write", 32'(if1.pc_write), 32'd0);
    chk("rt used stalling", 32'(if1.stalling), 32'd1);
    nxt(); idle();
    repeat (2) nxt();

    // $zero destination never hazards
    nxt(); memread = 1'b1; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; uses_rt = 1'b1;
    smp();
    chk("r0 stalling", 32'(if1.stalling), 32'd0);
    chk("r0 pc_write", 32'(if1.pc_write), 32'd1);
    chk("r0 x3 stalling", 32'(if3.stalling), 32'd0);

    // branch taken in the 2nd cycle of a 3-cycle stall
    nxt(); set_haz();
    smp();
    chk("ab stall", 32'(if3.stalling), 32'd1);
    nxt(); idle(); br = 1'b1; zero = 1'b1;
    smp();
    chk("ab pcsrc", 32'(if3.pcsrc), 32'd1);
    chk("ab flushes", {29'd0, if3.ifid_flush, if3.idex_flush, if3.exmem_flush}, 32'd7);
    chk("ab pc_write", 32'(if3.pc_write), 32'd1);
    nxt(); idle();
    smp();
    chk("ab after pc_write", 32'(if3.pc_write), 32'd1);
    chk("ab after stalling", 32'(if3.stalling), 32'd0);
    chk("ab flush_cnt", 32'(if3.flush_cnt), 32'd1);
    chk("ab stall_cnt", 32'(if3.stall_cnt), 32'd3);

    // zero flag without a branch
    nxt(); zero = 1'b1;
    smp();
    chk("zero only pcsrc", 32'(if1.pcsrc), 32'd0);

    // five taken branches saturate the 2-bit counter
    nxt(); br = 1'b1; zero = 1'b1;
    smp();
    repeat (4) begin nxt(); smp(); end
    nxt(); idle();
    smp();
    chk("sat flush_cnt", 32'(ifs.flush_cnt), 32'd3);
    nxt(); smp();
    chk("sat flush_cnt hold", 32'(ifs.flush_cnt), 32'd3);
    chk("wide flush_cnt", 32'(if1.flush_cnt), 32'd6);

    // hazard together with a taken branch: branch wins, stall not counted
    nxt(); set_haz(); br = 1'b1; zero = 1'b1;
    smp();
    chk("ht pc_write", 32'(if1.pc_write), 32'd1);
    chk("ht bubble", 32'(if1.idex_bubble), 32'd0);
    nxt(); idle();
    smp();
    chk("ht stall_cnt", 32'(if1.stall_cnt), 32'd3);
    chk("ht flush_cnt", 32'(if1.flush_cnt), 32'd7);
    chk("ht sat stall_cnt", 32'(ifs.stall_cnt), 32'd3);

    // reset during a stall abandons it
    nxt(); set_haz();
    smp();
    nxt(); idle(); rst = 1'b0;
    smp();
    chk("mid rst stalling", 32'(if3.stalling), 32'd0);
    chk("mid rst bubble", 32'(if3.idex_bubble), 32'd1);
    chk("mid rst stall_cnt", 32'(if3.stall_cnt), 32'd0);
    nxt(); rst = 1'b1;
    smp();
    chk("post rst stalling", 32'(if3.stalling), 32'd0);
    chk("post rst pc_write", 32'(if3.pc_write), 32'd1);

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sequences the execute datapath and the stages around it.
- Detects load-use data hazards between ID/EX and IF/ID and stalls PC and IF/ID while injecting bubbles into ID/EX.
- Resolves taken branches reported from EX/MEM (branch & zero) by redirecting the PC and flushing younger stages.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- STALL_CYCLES, 1, total stall cycles per load-use hazard (≥1; >1 models slow data memory)
- CNT_W, 16, width of each event counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- idex_memread  input  1  instruction in ID/EX is a load
- idex_rt  input  5  destination register of the ID/EX load
- ifid_rs  input  5  rs field of the IF/ID instruction
- ifid_rt  input  5  rt field of the IF/ID instruction
- ifid_uses_rt  input  1  IF/ID instruction reads rt (R-type, sw, beq)
- exmem_branch  input  1  EX/MEM holds a branch
- exmem_zero  input  1  EX/MEM ALU zero flag
- pc_write  output  1  PC may update
- ifid_write  output  1  IF/ID latch may load
- idex_bubble  output  1  force all ID/EX control bits (wb, mem, execute) to zero
- ifid_flush  output  1  clear IF/ID instruction to nop
- idex_flush  output  1  clear ID/EX control
- exmem_flush  output  1  clear EX/MEM control
- pcsrc  output  1  select branch target (EX/MEM add result) for next PC
- stalling  output  1  state is STALL, or a hazard is detected this cycle
- stall_cnt  output  CNT_W  number of hazard events, saturating
- flush_cnt  output  CNT_W  number of taken branches, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, remaining=0, stall_cnt=0, flush_cnt=0.
  - While rst=0, outputs are forced: pc_write=0, ifid_write=0, idex_bubble=1, all flushes=0, pcsrc=0, stalling=0.
- Reset release: deassertion takes effect at the next rising edge. Reset mid-stall abandons the stall.
- Hazard term (combinational): haz = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt))).
- Taken term: tkn = exmem_branch & exmem_zero.
- States: IDLE, STALL. All outputs are combinational from state plus the current inputs, so each takes effect in the same cycle.
- Priority: tkn > STALL > haz > normal.
- tkn (any state):
  - pcsrc=1, pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1, idex_bubble=0.
  - Next state IDLE, remaining=0; an in-progress stall is aborted.
  - flush_cnt increments. A hazard detected in the same cycle is ignored and not counted.
- IDLE with haz and no tkn:
  - pc_write=0, ifid_write=0, idex_bubble=1, stalling=1; stall_cnt increments.
  - If STALL_CYCLES=1: stay in IDLE. The load has then left ID/EX, so the hazard clears naturally.
  - Else: go to STALL with remaining=STALL_CYCLES-2.
- STALL with no tkn:
  - Same stall outputs as above; stall_cnt does not increment.
  - If remaining==0, go to IDLE; else decrement remaining.
  - The haz input is ignored in STALL, because ID/EX holds a bubble.
  - Total stall length = STALL_CYCLES cycles exactly.
- IDLE with neither tkn nor haz: pc_write=1, ifid_write=1, every other output 0.
- Counters: increment by 1 at the clock edge, saturate at 2^CNT_W-1, never wrap.
- remaining register width: clog2(STALL_CYCLES)+1.
- No other outputs are latched.

Test Plan:
- Reset: hold rst=0 for 3 cycles with haz inputs active -> pc_write=0, idex_bubble=1, stall_cnt=0, flush_cnt=0. Release -> with no hazard, pc_write=ifid_write=1 on the first edge.
- Load-use on rs (STALL_CYCLES=1): idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1.
- rt hazard gating:
  - idex_rt=9, ifid_rt=9, ifid_uses_rt=0 -> no stall.
  - Same with ifid_uses_rt=1 -> stall.
  - idex_rt=0 matching ifid_rs=0 -> no stall.
- Extended stall (STALL_CYCLES=3): hazard pulse for 1 cycle -> stalling=1 for exactly 3 consecutive cycles, then pc_write=1; stall_cnt=1.
- Branch abort (STALL_CYCLES=3): hazard, then tkn=1 in the 2nd stall cycle -> that cycle shows pcsrc=1 and all three flushes=1. Next cycle state is IDLE with pc_write=1; flush_cnt=1, stall_cnt=1.
- Saturation (CNT_W=2): 5 taken branches -> flush_cnt reads 3 and stays at 3; simultaneous haz+tkn -> stall_cnt unchanged.
